true2comp_serial: RTL and testbench
===================================

// Module: true2comp_serial
// PURPOSE
//   Bit-serial sign-magnitude (true form) to two's-complement converter for the calc7
//   datapath. It is the inverse of the comp2true0 stage.
//   It takes a W-bit true-form operand from keypad/display-side logic and returns the
//   two's-complement value for the arithmetic unit.
//   Conversion processes one magnitude bit per clock, LSB first: copy bits up to and
//   including the first '1', then invert the remaining bits.
//   Interface is a start/busy/done handshake.
// PARAMETERS
//   W   18   total word width; bit W-1 = sign, bits W-2..0 = magnitude
// PORTS
//   clk       in   1   system clock; all logic on posedge
//   rst       in   1   synchronous, active-high reset
//   start     in   1   request; sampled only while busy=0
//   datain    in   W   true-form operand; captured on the accepted start edge
//   busy      out  1   high from the edge after accept until done drops
//   done      out  1   one-cycle pulse; dataout is valid from this cycle onward
//   dataout   out  W   two's-complement result; held until the next accepted start
//   negzero   out  1   set with done when datain = {1'b1, W-1 zeros}; held like dataout
// BEHAVIOUR
//   Reset: one clock, synchronous, active-high; polarity and synchronicity are fixed.
//     - state=IDLE; busy=0, done=0, negzero=0, dataout=0; internal registers cleared.
//   States:
//     - IDLE: on start=1, capture sign, magnitude shift register, bit counter=0 and
//       seen_one=0, then go to SHIFT. Otherwise stay in IDLE.
//     - SHIFT: each cycle take magnitude LSB b and form the result bit.
//       - sign=0: output b.
//       - sign=1: output b^seen_one, then set seen_one |= b.
//       - Shift the result bit into the result register MSB-side; counter++.
//       - After W-1 bits, go to DONE.
//     - DONE: load dataout with the assembled word and pulse done=1 for this one cycle.
//       - MSB = sign & |magnitude.
//       - Next state is IDLE.
//   Latency: done is high exactly W cycles after the cycle in which start was sampled.
//     For W=18 that is 18 cycles; throughput is one conversion per W+1 cycles.
//   busy: 1 in SHIFT and DONE, 0 in IDLE. start while busy=1 is ignored; it is not queued.
//   Width and range rules:
//     - Input range is ±(2^(W-1)-1), so the output cannot overflow.
//     - Most-negative two's-complement code 100..0 is never produced.
//   Negative zero: datain = 1_000..0 gives dataout = 0 and negzero = 1.
//     Positive zero gives dataout = 0 and negzero = 0.
//   Simultaneous events:
//     - rst has priority over start and over any state.
//     - start asserted in the DONE cycle is ignored; it is accepted only in IDLE.
//   Reset mid-conversion: abort immediately to the reset values; no done pulse follows.
//   dataout and negzero change only in DONE or on reset, never during SHIFT.
// STRUCTURE
//   Shared include calc7_defs.vh holds:
//     - the word-width localparam CALC_W = 18
//     - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
//   comp2true0 and this block both use it.
//   Single module: the state register, bit counter ($clog2(W) bits), magnitude shift
//   register, result shift register and seen_one flop are all local. No sub-module.
// TESTING  (testbench true2comp_serial_tb, W=18; each case starts from IDLE)
//   1. datain=18'h00010 (+16), start for 1 cycle:
//      -> done 18 cycles later, dataout=18'h00010, negzero=0.
//   2. datain=18'h20080 (-128): -> dataout=18'h3FF80.
//      Then datain=18'h00080 (+128): -> dataout=18'h00080.
//   3. datain=18'h20010 (-16): -> dataout=18'h3FFF0.
//      datain=18'h3FFFF (-131071): -> dataout=18'h20001.
//   4. datain=18'h20000 (negative zero): -> dataout=0, negzero=1.
//      Then datain=0: -> dataout=0, negzero=0.
//   5. Assert start again on cycle 5 of a conversion, with a different datain:
//      -> it is ignored; result matches the first operand; busy stays high until done.
//   6. Assert rst on cycle 9 of a conversion of 18'h20080:
//      -> next cycle busy=0, dataout=0, no done pulse.
//      Then a new start converts correctly.
//   Self-check all cases against a behavioural model: sign ? -mag : mag.
//   Cross-check by feeding dataout into comp2true0 and requiring the original datain
//   back (negative zero excepted).

Source files
------------

// File: rtl/true2comp_serial_pkg.sv
// Shared definitions for the calc7 true-form / two's-complement converters.
package true2comp_serial_pkg;

  // Datapath word width: bit CALC_W-1 is the sign, the rest is the magnitude.
  localparam int CALC_W = 18;

  // Converter states. The encodings are shared with comp2true0.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/true2comp_serial.sv
// Bit-serial sign-magnitude to two's-complement converter.
// Processes one magnitude bit per clock, LSB first. For a negative operand the
// bits up to and including the first '1' are copied and the rest are inverted.
//
// Handshake: start is sampled only in IDLE (busy=0). The cycle after an accepted
// start, busy rises and stays high through SHIFT and DONE. done is a one-cycle
// pulse in DONE. dataout/negzero are valid from that cycle and are held until
// the next conversion completes. A start seen while busy=1 is dropped, not queued.
module true2comp_serial
  import true2comp_serial_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] datain,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dataout,
  output logic         negzero,
  output state_t       state_dbg
);

  localparam int              CW   = $clog2(W);
  localparam logic [CW-1:0]   LAST = CW'(W - 2);

  state_t         state;
  state_t         state_next;
  logic           sign;
  logic [W-2:0]   mag;
  logic [W-2:0]   res;
  logic [CW-1:0]  cnt;
  logic           seen_one;

  logic           bit_in;
  logic           bit_out;
  logic           seen_next;
  logic           last_bit;

  // Per-bit conversion: copy until the first '1' (inclusive), then invert.
  always_comb begin
    bit_in    = mag[0];
    bit_out   = sign ? (bit_in ^ seen_one) : bit_in;
    seen_next = seen_one | (sign & bit_in);
    last_bit  = (state == ST_SHIFT) && (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture, serial shift, and result load.
  // The result word is assembled on the edge that leaves SHIFT so that
  // dataout is already valid during the DONE cycle when done is high.
  // For a negative operand seen_next on the last bit equals |magnitude,
  // which gives both the result sign and the negative-zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign     <= 1'b0;
      mag      <= '0;
      res      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      dataout  <= '0;
      negzero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign     <= datain[W-1];
            mag      <= datain[W-2:0];
            res      <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
          end
        end
        ST_SHIFT: begin
          mag      <= mag >> 1;
          res      <= {bit_out, res[W-2:1]};
          cnt      <= cnt + 1'b1;
          seen_one <= seen_next;
          if (last_bit) begin
            dataout <= {sign & seen_next, bit_out, res[W-2:1]};
            negzero <= sign & ~seen_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_true2comp_serial.sv
// Directed bench for true2comp_serial (W=18).
module tb_true2comp_serial;
  import true2comp_serial_pkg::*;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] datain = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] dataout;
  logic         negzero;
  state_t       state_dbg;

  int checks = 0;
  int failures = 0;

  true2comp_serial #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .datain    (datain),
    .busy      (busy),
    .done      (done),
    .dataout   (dataout),
    .negzero   (negzero),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Reference: sign ? -mag : mag.
  function automatic logic [W-1:0] to_twos(input logic [W-1:0] d);
    logic [W-1:0] m;
    m = {1'b0, d[W-2:0]};
    return d[W-1] ? (~m + 1'b1) : m;
  endfunction

  // Inverse reference (what comp2true0 does): two's complement back to true form.
  function automatic logic [W-1:0] to_true(input logic [W-1:0] x);
    logic [W-1:0] n;
    n = ~x + 1'b1;
    return x[W-1] ? {1'b1, n[W-2:0]} : x;
  endfunction

  // Driver: issues one start (called just after a negedge), then samples at
  // each negedge until done. lat=0 means done never appeared within the budget.
  // again_at: negedge index at which start is re-asserted for one cycle with d2.
  task automatic conv(input logic [W-1:0] d, input int again_at,
                      input logic [W-1:0] d2, output int lat,
                      output logic [W-1:0] dout, output logic nz,
                      output int busy_bad, output int dout_moved);
    logic [W-1:0] d0;
    d0 = dataout;
    lat = 0;
    busy_bad = 0;
    dout_moved = 0;
    dout = 'x;
    nz = 1'bx;
    datain = d;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        dout = dataout;
        nz = negzero;
        start = 1'b0;
        break;
      end
      if (!busy) busy_bad++;
      if (dataout !== d0) dout_moved++;
      if (i == again_at) begin
        start = 1'b1;
        datain = d2;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || negzero !== 1'b0 || dataout !== '0 ||
        state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset busy=%b done=%b negzero=%b dataout=%h state=%0d want 0/0/0/0/IDLE",
               busy, done, negzero, dataout, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conversions();
    logic [W-1:0] vin [9];
    logic [W-1:0] vexp [9];
    logic         vnz [9];
    int lat, bb, dm;
    logic [W-1:0] dout;
    logic nz;
    vin[0] = 18'h00010; vexp[0] = 18'h00010; vnz[0] = 1'b0;
    vin[1] = 18'h20080; vexp[1] = 18'h3FF80; vnz[1] = 1'b0;
    vin[2] = 18'h00080; vexp[2] = 18'h00080; vnz[2] = 1'b0;
    vin[3] = 18'h20010; vexp[3] = 18'h3FFF0; vnz[3] = 1'b0;
    vin[4] = 18'h3FFFF; vexp[4] = 18'h20001; vnz[4] = 1'b0;
    vin[5] = 18'h20000; vexp[5] = 18'h00000; vnz[5] = 1'b1;
    vin[6] = 18'h00000; vexp[6] = 18'h00000; vnz[6] = 1'b0;
    vin[7] = 18'h20001; vexp[7] = 18'h3FFFF; vnz[7] = 1'b0;
    vin[8] = 18'h1FFFF; vexp[8] = 18'h1FFFF; vnz[8] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      conv(vin[k], 0, '0, lat, dout, nz, bb, dm);
      checks++;
      if (lat !== W) begin
        failures++;
        $display("FAIL latency in=%h got=%0d want=%0d", vin[k], lat, W);
      end
      checks++;
      if (dout !== vexp[k]) begin
        failures++;
        $display("FAIL dataout in=%h got=%h want=%h", vin[k], dout, vexp[k]);
      end
      checks++;
      if (dout !== to_twos(vin[k])) begin
        failures++;
        $display("FAIL model in=%h got=%h want=%h", vin[k], dout, to_twos(vin[k]));
      end
      checks++;
      if (nz !== vnz[k]) begin
        failures++;
        $display("FAIL negzero in=%h got=%b want=%b", vin[k], nz, vnz[k]);
      end
      if (!vnz[k]) begin
        checks++;
        if (to_true(dout) !== vin[k]) begin
          failures++;
          $display("FAIL roundtrip in=%h got=%h want=%h", vin[k], to_true(dout), vin[k]);
        end
      end
      checks++;
      if (bb != 0 || dm != 0) begin
        failures++;
        $display("FAIL shift_phase in=%h busy_low_cycles=%0d dataout_changes=%0d want 0/0",
                 vin[k], bb, dm);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dataout !== vexp[k] || negzero !== vnz[k]) begin
        failures++;
        $display("FAIL after_done in=%h done=%b busy=%b dataout=%h negzero=%b want 0/0/%h/%b",
                 vin[k], done, busy, dataout, negzero, vexp[k], vnz[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, bb, dm;
    logic [W-1:0] dout;
    logic nz;
    conv(18'h20010, 5, 18'h00123, lat, dout, nz, bb, dm);
    checks++;
    if (lat !== W || dout !== 18'h3FFF0 || nz !== 1'b0) begin
      failures++;
      $display("FAIL start_busy lat=%0d dataout=%h negzero=%b want %0d/3fff0/0",
               lat, dout, nz, W);
    end
    checks++;
    if (bb != 0) begin
      failures++;
      $display("FAIL start_busy_level busy_low_cycles=%0d want 0", bb);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL start_busy_idle busy=%b state=%0d want 0/IDLE", busy, state_dbg);
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    int lat, bb, dm;
    logic [W-1:0] dout;
    logic nz;
    datain = 18'h20080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dataout !== '0 || negzero !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid busy=%b dataout=%h negzero=%b done=%b want 0/0/0/0",
               busy, dataout, negzero, done);
    end
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL reset_mid_done got=%0d pulses want=0", spurious);
    end
    conv(18'h20080, 0, '0, lat, dout, nz, bb, dm);
    checks++;
    if (lat !== W || dout !== 18'h3FF80 || dm != 0) begin
      failures++;
      $display("FAIL reset_mid_restart lat=%0d dataout=%h changes=%0d want %0d/3ff80/0",
               lat, dout, dm, W);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic [W-1:0] d1;
    t1 = 0;
    t2 = 0;
    d1 = 'x;
    datain = 18'h20080;
    start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done && t1 == 0) begin
        t1 = i;
        d1 = dataout;
        datain = 18'h00010;
      end else if (done && t1 != 0) begin
        t2 = i;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (t1 !== W || d1 !== 18'h3FF80) begin
      failures++;
      $display("FAIL b2b_first lat=%0d dataout=%h want %0d/3ff80", t1, d1, W);
    end
    checks++;
    if (t2 - t1 !== W + 1 || dataout !== 18'h00010) begin
      failures++;
      $display("FAIL b2b_second interval=%0d dataout=%h want %0d/00010",
               t2 - t1, dataout, W + 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
